kmeans_assign_accum: RTL and testbench
======================================

Name: kmeans_assign_accum

Overview:
Parametrised successor to the fixed 5-cluster assign and sum stages. It takes 2-D points over a valid/ready stream and scans K programmable centroids sequentially, one per cycle, to find the nearest by squared Euclidean distance. It emits the winning label and accumulates per-cluster coordinate sums and counts. The sums and counts feed the centroid-update divider stage; the top-level kmeans sequencer drives clr, centroid loads and point streaming.

Parameters:
COORD_W, 14, unsigned coordinate width
K, 5, number of clusters (2..16)
IDX_W, 3, label width, must satisfy 2^IDX_W >= K
SUM_W, 24, per-cluster coordinate sum width
CNT_W, 14, per-cluster count width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of sums/counts/sat
cen_we  in  1  centroid write strobe
cen_idx  in  IDX_W  centroid index to write
cen_x  in  COORD_W  centroid x
cen_y  in  COORD_W  centroid y
pt_valid  in  1  point offered
pt_ready  out  1  block can accept point
pt_x  in  COORD_W  point x
pt_y  in  COORD_W  point y
lbl_valid  out  1  one-cycle pulse, label valid
lbl  out  IDX_W  nearest-centroid index
busy  out  1  high in SCAN or WRITE
sat  out  1  sticky, any sum or count saturated
rd_idx  in  IDX_W  readout select
rd_sum_x  out  SUM_W  sum_x[rd_idx], combinational from registers
rd_sum_y  out  SUM_W  sum_y[rd_idx]
rd_cnt  out  CNT_W  cnt[rd_idx]

Behaviour:
- Reset (async, rst_n=0): state IDLE; all centroids, sums, counts = 0; pt_ready=0 during reset, 1 first cycle after; lbl_valid=0, lbl=0, busy=0, sat=0.
- FSM IDLE -> SCAN -> WRITE -> IDLE.
- IDLE: pt_ready=1. Transfer on pt_valid&pt_ready: latch pt_x/pt_y, scan ptr=0, best_dist=all-ones, best_idx=0; go SCAN.
- SCAN: K cycles, pointer k=0..K-1. dist = (|x-cx|)^2 + (|y-cy|)^2, width 2*COORD_W+1, no truncation. Update best only if dist < best_dist (strict), so ties resolve to lowest index. After k=K-1 go WRITE.
- WRITE (1 cycle): lbl_valid=1, lbl=best_idx. sum_x[best]+=x, sum_y[best]+=y, cnt[best]+=1, each saturating at all-ones; any saturation sets sat. Next state IDLE.
- Latency: transfer at edge T; lbl_valid high in cycle T+K+1; pt_ready high again cycle T+K+2. Throughput one point per K+2 cycles.
- cen_we: honoured only when busy=0; ignored while busy (centroids stable during a scan). cen_idx >= K ignored.
- clr: highest priority after reset. Zeroes sums, counts and sat. Aborts an in-flight point: no lbl_valid, no accumulation, state -> IDLE. Centroids are not affected. A clr coinciding with a pt transfer discards the point.
- rd_idx >= K: readout outputs 0.
- Count equal to 0 for a cluster is legal; the downstream divider handles it.

Optional Feature:
KMEANS_SSE_EN: when defined, adds output port sse (width 2*COORD_W+1+CNT_W). In WRITE it accumulates best_dist, saturating and setting sat on overflow. It is cleared by clr and reset. When undefined, port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, load centroids (0,0),(0,10000),(10000,0),(10000,10000),(5000,5000); send (100,200) -> lbl=0 at T+6, rd_idx=0 gives sum_x=100, sum_y=200, cnt=1; with KMEANS_SSE_EN, sse=50000.
- Tie: send (5000,0), equidistant 25000000 to clusters 0, 2 and 4 -> lbl=0; send (9000,9100) -> lbl=3, cnt[3]=1.
- Saturation: SUM_W=24, send 1025 points (16383,0) near cluster 2 -> sum_x[2]=16777215, cnt[2]=1025, sat=1; clr -> all 0, sat=0.
- clr in 3rd SCAN cycle -> no lbl_valid, counts unchanged, pt_ready=1 next cycle; cen_we during SCAN -> centroid unchanged on readback via label test.
- rst_n low mid-WRITE -> outputs immediately at reset values, centroids zero, next point with all centroids (0,0) -> lbl=0.
- Back-to-back pt_valid held high, 4 points -> lbl_valid pulses spaced exactly K+2=7 cycles, pt_ready low during each scan.

Source files
------------

// File: rtl/kmeans_assign_accum_if.sv
// Point-in / label-out stream bundle for kmeans_assign_accum.
// The slave side accepts points and returns the nearest-centroid label.
interface kmeans_assign_accum_if #(
    parameter int COORD_W = 14,
    parameter int IDX_W   = 3
);
    logic               pt_valid;
    logic               pt_ready;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic               lbl_valid;
    logic [IDX_W-1:0]   lbl;

    modport master (
        output pt_valid, pt_x, pt_y,
        input  pt_ready, lbl_valid, lbl
    );

    modport slave (
        input  pt_valid, pt_x, pt_y,
        output pt_ready, lbl_valid, lbl
    );
endinterface

// File: rtl/kmeans_assign_accum.sv
// K-centroid nearest-neighbour assignment with saturating per-cluster sums/counts.
// Optional macro KMEANS_SSE_EN adds a saturating sum-of-squared-error output (sse).
module kmeans_assign_accum #(
    parameter int COORD_W = 14,
    parameter int K       = 5,
    parameter int IDX_W   = 3,
    parameter int SUM_W   = 24,
    parameter int CNT_W   = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                cen_we,
    input  logic [IDX_W-1:0]    cen_idx,
    input  logic [COORD_W-1:0]  cen_x,
    input  logic [COORD_W-1:0]  cen_y,
    kmeans_assign_accum_if.slave pt_if,
    output logic                busy,
    output logic                sat,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [SUM_W-1:0]    rd_sum_x,
    output logic [SUM_W-1:0]    rd_sum_y,
    output logic [CNT_W-1:0]    rd_cnt
`ifdef KMEANS_SSE_EN
    ,
    output logic [2*COORD_W+CNT_W:0] sse
`endif
);

    localparam int DIST_W = 2 * COORD_W + 1;
    localparam int NSLOT  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
    localparam logic [IDX_W:0]   K_EXT    = (IDX_W + 1)'(K);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Saturating adders return {overflow, result}; result is all-ones on overflow.
    function automatic logic [SUM_W:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W + 1)'(b);
        if (s[SUM_W]) begin
            return {1'b1, {SUM_W{1'b1}}};
        end else begin
            return s;
        end
    endfunction

    function automatic logic [CNT_W:0] sat_inc_cnt(input logic [CNT_W-1:0] a);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{CNT_W{1'b0}}, 1'b1};
        if (s[CNT_W]) begin
            return {1'b1, {CNT_W{1'b1}}};
        end else begin
            return s;
        end
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [COORD_W-1:0]  px_q, px_d, py_q, py_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                pt_ready_q, pt_ready_d;
    logic                lbl_valid_q, lbl_valid_d;
    logic [IDX_W-1:0]    lbl_q, lbl_d;
    logic                busy_q, busy_d;
    logic                sat_q, sat_d;

    logic [COORD_W-1:0]  cen_x_q [NSLOT];
    logic [COORD_W-1:0]  cen_x_d [NSLOT];
    logic [COORD_W-1:0]  cen_y_q [NSLOT];
    logic [COORD_W-1:0]  cen_y_d [NSLOT];
    logic [SUM_W-1:0]    sum_x_q [NSLOT];
    logic [SUM_W-1:0]    sum_x_d [NSLOT];
    logic [SUM_W-1:0]    sum_y_q [NSLOT];
    logic [SUM_W-1:0]    sum_y_d [NSLOT];
    logic [CNT_W-1:0]    cnt_q   [NSLOT];
    logic [CNT_W-1:0]    cnt_d   [NSLOT];

    logic [COORD_W-1:0]   dx_s, dy_s;
    logic [2*COORD_W-1:0] sqx_s, sqy_s;
    logic [DIST_W-1:0]    dist_s;
    logic [SUM_W:0]       sx_s, sy_s;
    logic [CNT_W:0]       cn_s;
    logic                 xfer_s;

`ifdef KMEANS_SSE_EN
    localparam int SSE_W = DIST_W + CNT_W;
    logic [SSE_W-1:0] sse_q, sse_d;
    logic [SSE_W:0]   se_s;
`endif

    // Squared Euclidean distance from the latched point to the centroid under the scan pointer.
    always_comb begin
        if (px_q >= cen_x_q[ptr_q]) begin
            dx_s = px_q - cen_x_q[ptr_q];
        end else begin
            dx_s = cen_x_q[ptr_q] - px_q;
        end
        if (py_q >= cen_y_q[ptr_q]) begin
            dy_s = py_q - cen_y_q[ptr_q];
        end else begin
            dy_s = cen_y_q[ptr_q] - py_q;
        end
        sqx_s  = {{COORD_W{1'b0}}, dx_s} * {{COORD_W{1'b0}}, dx_s};
        sqy_s  = {{COORD_W{1'b0}}, dy_s} * {{COORD_W{1'b0}}, dy_s};
        dist_s = {1'b0, sqx_s} + {1'b0, sqy_s};
    end

    // Next-state logic: scan FSM, centroid table, accumulators and registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        px_d        = px_q;
        py_d        = py_q;
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        lbl_valid_d = 1'b0;
        lbl_d       = lbl_q;
        sat_d       = sat_q;
        cen_x_d     = cen_x_q;
        cen_y_d     = cen_y_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        cnt_d       = cnt_q;
        xfer_s      = pt_if.pt_valid & pt_ready_q;
        sx_s        = sat_add_sum(sum_x_q[best_idx_q], px_q);
        sy_s        = sat_add_sum(sum_y_q[best_idx_q], py_q);
        cn_s        = sat_inc_cnt(cnt_q[best_idx_q]);
`ifdef KMEANS_SSE_EN
        sse_d = sse_q;
        se_s  = {1'b0, sse_q} + (SSE_W + 1)'(best_dist_q);
`endif

        // Centroids are frozen while a point is in flight so a scan sees one consistent set.
        if (cen_we && (state_q == ST_IDLE) && ({1'b0, cen_idx} < K_EXT)) begin
            cen_x_d[cen_idx] = cen_x;
            cen_y_d[cen_idx] = cen_y;
        end else begin
            cen_x_d[0] = cen_x_q[0];
        end

        if (clr) begin
            state_d = ST_IDLE;
            sat_d   = 1'b0;
            sum_x_d = '{default: '0};
            sum_y_d = '{default: '0};
            cnt_d   = '{default: '0};
`ifdef KMEANS_SSE_EN
            sse_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer_s) begin
                        px_d        = pt_if.pt_x;
                        py_d        = pt_if.pt_y;
                        ptr_d       = '0;
                        best_dist_d = '1;
                        best_idx_d  = '0;
                        state_d     = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (dist_s < best_dist_q) begin
                        best_dist_d = dist_s;
                        best_idx_d  = ptr_q;
                    end else begin
                        best_dist_d = best_dist_q;
                    end
                    if (ptr_q == LAST_IDX) begin
                        state_d     = ST_WRITE;
                        lbl_valid_d = 1'b1;
                        lbl_d       = best_idx_d;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1'b1);
                    end
                end
                ST_WRITE: begin
                    sum_x_d[best_idx_q] = sx_s[SUM_W-1:0];
                    sum_y_d[best_idx_q] = sy_s[SUM_W-1:0];
                    cnt_d[best_idx_q]   = cn_s[CNT_W-1:0];
                    sat_d = sat_q | sx_s[SUM_W] | sy_s[SUM_W] | cn_s[CNT_W];
`ifdef KMEANS_SSE_EN
                    if (se_s[SSE_W]) begin
                        sse_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        sse_d = se_s[SSE_W-1:0];
                    end
`endif
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        pt_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            best_dist_q <= '1;
            best_idx_q  <= '0;
            pt_ready_q  <= 1'b0;
            lbl_valid_q <= 1'b0;
            lbl_q       <= '0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                cen_x_q[i] <= '0;
                cen_y_q[i] <= '0;
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
`ifdef KMEANS_SSE_EN
            sse_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            px_q        <= px_d;
            py_q        <= py_d;
            best_dist_q <= best_dist_d;
            best_idx_q  <= best_idx_d;
            pt_ready_q  <= pt_ready_d;
            lbl_valid_q <= lbl_valid_d;
            lbl_q       <= lbl_d;
            busy_q      <= busy_d;
            sat_q       <= sat_d;
            cen_x_q     <= cen_x_d;
            cen_y_q     <= cen_y_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            cnt_q       <= cnt_d;
`ifdef KMEANS_SSE_EN
            sse_q <= sse_d;
`endif
        end
    end

    // Readout mux; out-of-range selects read as zero.
    always_comb begin
        if ({1'b0, rd_idx} < K_EXT) begin
            rd_sum_x = sum_x_q[rd_idx];
            rd_sum_y = sum_y_q[rd_idx];
            rd_cnt   = cnt_q[rd_idx];
        end else begin
            rd_sum_x = '0;
            rd_sum_y = '0;
            rd_cnt   = '0;
        end
    end

    assign pt_if.pt_ready  = pt_ready_q;
    assign pt_if.lbl_valid = lbl_valid_q;
    assign pt_if.lbl       = lbl_q;
    assign busy            = busy_q;
    assign sat             = sat_q;
`ifdef KMEANS_SSE_EN
    assign sse             = sse_q;
`endif

endmodule

// File: tb/tb_kmeans_assign_accum.sv
// Directed self-checking bench for kmeans_assign_accum (default K=5 configuration).
module tb_kmeans_assign_accum;
    localparam int COORD_W = 14;
    localparam int K       = 5;
    localparam int IDX_W   = 3;
    localparam int SUM_W   = 24;
    localparam int CNT_W   = 14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               cen_we;
    logic [IDX_W-1:0]   cen_idx;
    logic [COORD_W-1:0] cen_x, cen_y;
    logic               busy, sat;
    logic [IDX_W-1:0]   rd_idx;
    logic [SUM_W-1:0]   rd_sum_x, rd_sum_y;
    logic [CNT_W-1:0]   rd_cnt;
`ifdef KMEANS_SSE_EN
    logic [2*COORD_W+CNT_W:0] sse;
`endif

    int checks   = 0;
    int failures = 0;

    kmeans_assign_accum_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) bus ();

    kmeans_assign_accum #(
        .COORD_W(COORD_W), .K(K), .IDX_W(IDX_W), .SUM_W(SUM_W), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .cen_we   (cen_we),
        .cen_idx  (cen_idx),
        .cen_x    (cen_x),
        .cen_y    (cen_y),
        .pt_if    (bus),
        .busy     (busy),
        .sat      (sat),
        .rd_idx   (rd_idx),
        .rd_sum_x (rd_sum_x),
        .rd_sum_y (rd_sum_y),
        .rd_cnt   (rd_cnt)
`ifdef KMEANS_SSE_EN
        ,
        .sse      (sse)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cen(input int idx, input int x, input int y);
        cen_we  = 1'b1;
        cen_idx = IDX_W'(idx);
        cen_x   = COORD_W'(x);
        cen_y   = COORD_W'(y);
        tick();
        cen_we  = 1'b0;
    endtask

    task automatic rd_check(input int idx, input int sx, input int sy, input int cn, input string tag);
        rd_idx = IDX_W'(idx);
        #1;
        check({tag, "_sum_x"}, rd_sum_x, sx);
        check({tag, "_sum_y"}, rd_sum_y, sy);
        check({tag, "_cnt"}, rd_cnt, cn);
    endtask

    // Offer one point, then check label latency, label value and return to ready.
    task automatic send_point(input int x, input int y, input int exp_lbl, input string tag);
        int n;
        bus.pt_valid = 1'b1;
        bus.pt_x     = COORD_W'(x);
        bus.pt_y     = COORD_W'(y);
        n = 0;
        while (!bus.pt_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.pt_valid = 1'b0;
        n = 0;
        while (!bus.lbl_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, K);
        check({tag, "_lbl"}, bus.lbl, exp_lbl);
        tick();
        check({tag, "_ready_after"}, {bus.pt_ready, bus.lbl_valid}, 2'b10);
    endtask

    initial begin
        int n;
        int xfers, pulses, viol, cyc;
        int pulse_t [4];

        rst_n = 1'b0; clr = 1'b0; cen_we = 1'b0; cen_idx = '0; cen_x = '0; cen_y = '0;
        rd_idx = '0; bus.pt_valid = 1'b0; bus.pt_x = '0; bus.pt_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pt_ready", bus.pt_ready, 0);
        check("rst_lbl_valid", bus.lbl_valid, 0);
        check("rst_lbl", bus.lbl, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready_after", bus.pt_ready, 1);

        load_cen(0, 0, 0);
        load_cen(1, 0, 10000);
        load_cen(2, 10000, 0);
        load_cen(3, 10000, 10000);
        load_cen(4, 5000, 5000);

        send_point(100, 200, 0, "p1");
        rd_check(0, 100, 200, 1, "p1_rd0");
`ifdef KMEANS_SSE_EN
        check("p1_sse", sse, 50000);
`endif
        send_point(5000, 0, 0, "tie");
        send_point(9000, 9100, 3, "p3");
        rd_check(3, 9000, 9100, 1, "p3_rd3");
        rd_check(0, 5100, 200, 2, "p3_rd0");
        rd_check(5, 0, 0, 0, "rd_oob5");
        rd_check(7, 0, 0, 0, "rd_oob7");
`ifdef KMEANS_SSE_EN
        check("p3_sse", sse, 26860000);
`endif

        // Saturation: 1024 points fit in 24 bits, the 1025th overflows sum_x[2].
        for (int i = 0; i < 1024; i++) send_point(16383, 0, 2, "satfill");
        rd_check(2, 16776192, 0, 1024, "sat_pre");
        check("sat_pre_flag", sat, 0);
        send_point(16383, 0, 2, "satlast");
        rd_check(2, 16777215, 0, 1025, "sat_post");
        check("sat_post_flag", sat, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_sat", sat, 0);
        rd_check(2, 0, 0, 0, "clr_rd2");
        rd_check(0, 0, 0, 0, "clr_rd0");
        rd_check(3, 0, 0, 0, "clr_rd3");
`ifdef KMEANS_SSE_EN
        check("clr_sse", sse, 0);
`endif

        // Abort an in-flight point with clr in its third scan cycle.
        bus.pt_valid = 1'b1; bus.pt_x = 14'd100; bus.pt_y = 14'd200;
        tick();
        bus.pt_valid = 1'b0;
        tick();
        tick();
        check("abort_busy_scan", busy, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_ready", bus.pt_ready, 1);
        check("abort_busy", busy, 0);
        n = 0;
        for (int i = 0; i < K + 2; i++) begin
            if (bus.lbl_valid) n++;
            tick();
        end
        check("abort_no_lbl", n, 0);
        rd_check(0, 0, 0, 0, "abort_rd0");

        // Centroid write during a scan must be ignored.
        bus.pt_valid = 1'b1; bus.pt_x = 14'd9900; bus.pt_y = 14'd9900;
        tick();
        bus.pt_valid = 1'b0;
        tick();
        cen_we = 1'b1; cen_idx = 3'd0; cen_x = 14'd9900; cen_y = 14'd9900;
        tick();
        cen_we = 1'b0;
        repeat (K + 1) tick();
        send_point(9900, 9900, 3, "cenwe_busy");
        load_cen(1, 9900, 9900);
        send_point(9900, 9900, 1, "cenwe_idle");

        // Back-to-back points with pt_valid held high.
        bus.pt_valid = 1'b1; bus.pt_x = 14'd100; bus.pt_y = 14'd200;
        xfers = 0; pulses = 0; viol = 0; cyc = 0;
        while (pulses < 4 && cyc < 100) begin
            if (bus.pt_valid && bus.pt_ready) xfers++;
            tick();
            cyc++;
            if (xfers == 4) bus.pt_valid = 1'b0;
            if (bus.lbl_valid) begin
                pulse_t[pulses] = cyc;
                pulses++;
            end
            if (busy && bus.pt_ready) viol++;
        end
        tick();
        check("b2b_pulses", pulses, 4);
        check("b2b_gap1", pulse_t[1] - pulse_t[0], K + 2);
        check("b2b_gap2", pulse_t[2] - pulse_t[1], K + 2);
        check("b2b_gap3", pulse_t[3] - pulse_t[2], K + 2);
        check("b2b_ready_busy", viol, 0);
        rd_check(0, 400, 800, 4, "b2b_rd0");

        // Asynchronous reset asserted during WRITE.
        bus.pt_valid = 1'b1; bus.pt_x = 14'd100; bus.pt_y = 14'd200;
        tick();
        bus.pt_valid = 1'b0;
        repeat (K) tick();
        check("mid_write_lbl_valid", bus.lbl_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_lbl_valid", bus.lbl_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", bus.pt_ready, 0);
        rd_check(0, 0, 0, 0, "arst_rd0");
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_ready_after", bus.pt_ready, 1);
        send_point(9900, 9900, 0, "zero_cen");
        rd_check(0, 9900, 9900, 1, "zero_cen_rd0");
        rd_check(1, 0, 0, 0, "zero_cen_rd1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
